// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
//
// Shared definitions for the raster stream source and any other block that
// walks the same raster, such as the upsampler-side timing.
//   - raster_state_t : raster position class (IDLE / ACTIVE / HBLANK / VBLANK)
//   - CNT_W          : width of the row/column counters (rasters up to 1024)
//   - DATA_W         : pixel width
//   - BLANK_FILL     : pixel value driven during blanking and empty slots
//   - slot_state()   : classifies a counter position into ACTIVE/HBLANK/VBLANK
// -----------------------------------------------------------------------------
package raster_pkg;

    localparam int CNT_W  = 10;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] BLANK_FILL = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } raster_state_t;

    // Vertical blanking takes precedence: a whole blanking row is VBLANK,
    // including the columns that would be active on an active row.
    function automatic raster_state_t slot_state(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] h_active,
        input logic [CNT_W-1:0] v_active
    );
        if (v >= v_active) begin
            return VBLANK;
        end else if (h >= h_active) begin
            return HBLANK;
        end else begin
            return ACTIVE;
        end
    endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
//
// Horizontal/vertical slot counters for one raster. h runs 0..H_TOTAL-1 and
// v runs 0..V_TOTAL-1; both wrap to 0. The next position is exported
// combinationally so a controller can classify the upcoming slot in the same
// cycle it decides its next state.
//
// Ports:
//   clock        in   sole clock
//   reset        in   synchronous active-low reset (counters to 0)
//   clear        in   hold both counters at 0 (takes priority over advance)
//   advance      in   step one slot this cycle
//   h, v         out  current column / row
//   h_next       out  column the counter moves to on the next advance
//   v_next       out  row the counter moves to on the next advance
//   end_of_frame out  current slot is the last one of the frame
// -----------------------------------------------------------------------------
module raster_counter
    import raster_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic [CNT_W-1:0] h_next,
    output logic [CNT_W-1:0] v_next,
    output logic             end_of_frame
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic h_last;
    logic v_last;

    always_comb begin
        h_last       = (h == H_LAST);
        v_last       = (v == V_LAST);
        end_of_frame = h_last && v_last;
        h_next       = h_last ? '0 : h + 1'b1;
        if (h_last) begin
            v_next = v_last ? '0 : v + 1'b1;
        end else begin
            v_next = v;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            h <= '0;
            v <= '0;
        end else if (advance) begin
            h <= h_next;
            v <= v_next;
        end
    end

endmodule

// File: rtl/raster_stream_source.sv
// -----------------------------------------------------------------------------
// raster_stream_source
//
// Raster transmitter feeding the downsampler front end. Pops pixels from an
// upstream FIFO-style source and places them on a fixed raster of
// (H_ACTIVE + H_BLANK) x (V_ACTIVE + V_BLANK) slots, one slot per cycle,
// with registered outputs one cycle behind the slot. Raster timing never
// stalls: an active slot with no upstream pixel emits 8'h00 as a valid pixel
// and sets the sticky underflow flag. Frames always run to completion once
// started; dropping run only takes effect at the end of the frame.
//
// Optional build macro: RASTER_TEST_PATTERN_EN
//   Adds input pattern_sel. When it is 1 at frame start, the whole frame's
//   active pixels become colcount[7:0] ^ rowcount[7:0], nothing is popped
//   upstream and underflow cannot be set.
//
// Ports:
//   clock          in   sole clock
//   reset          in   synchronous active-low reset
//   run            in   level; start/continue frames
//   din            in   upstream pixel
//   din_valid      in   upstream has a pixel
//   pattern_sel    in   (RASTER_TEST_PATTERN_EN only) test pattern select
//   din_ready      out  upstream pixel is popped this cycle
//   dout           out  pixel to downsampler
//   validout       out  dout is an active pixel
//   blankingregion out  current raster slot is blanking (H or V)
//   rowcount       out  row of the current slot
//   colcount       out  column of the current slot
//   frame_start    out  one-cycle pulse with pixel (0,0)
//   underflow      out  sticky: an active slot found din_valid low
// -----------------------------------------------------------------------------
module raster_stream_source
    import raster_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
`ifdef RASTER_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              validout,
    output logic              blankingregion,
    output logic [CNT_W-1:0]  rowcount,
    output logic [CNT_W-1:0]  colcount,
    output logic              frame_start,
    output logic              underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);

    function automatic logic [DATA_W-1:0] pattern_pixel(
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] col
    );
        return col[DATA_W-1:0] ^ row[DATA_W-1:0];
    endfunction

    raster_state_t state;
    raster_state_t next_state;

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             end_of_frame;
    logic             counter_clear;

    logic              pat_q;
    logic [DATA_W-1:0] slot_pixel;

    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
    logic              blank_p1;
    logic [CNT_W-1:0]  row_p1;
    logic [CNT_W-1:0]  col_p1;
    logic              fs_p1;
    logic              underflow_q;

    // Counters sit at (0,0) while idle so the first slot after start is (0,0).
    assign counter_clear = (state == IDLE);

    raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clock        (clock),
        .reset        (reset),
        .clear        (counter_clear),
        .advance      (1'b1),
        .h            (h),
        .v            (v),
        .h_next       (h_next),
        .v_next       (v_next),
        .end_of_frame (end_of_frame)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (run) begin
                    next_state = ACTIVE;
                end
            end
            default: begin
                // run is only consulted at the frame boundary.
                if (end_of_frame) begin
                    next_state = run ? ACTIVE : IDLE;
                end else begin
                    next_state = slot_state(h_next, v_next, H_ACTIVE_C, V_ACTIVE_C);
                end
            end
        endcase
    end

`ifdef RASTER_TEST_PATTERN_EN
    logic frame_begin;

    // pattern_sel is captured on the edge that enters slot (0,0) and held
    // for the rest of the frame.
    assign frame_begin = (next_state == ACTIVE) && ((state == IDLE) || end_of_frame);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pat_q <= 1'b0;
        end else if (frame_begin) begin
            pat_q <= pattern_sel;
        end
    end
`else
    assign pat_q = 1'b0;
`endif

    // Pop whenever an active slot is live, whether or not upstream has data.
    assign din_ready = (state == ACTIVE) && !pat_q;

    always_comb begin
        if (pat_q) begin
            slot_pixel = pattern_pixel(v, h);
        end else if (din_valid) begin
            slot_pixel = din;
        end else begin
            slot_pixel = BLANK_FILL;
        end
    end

    // ---- stage p1: registered stream outputs, one cycle behind the slot ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            dout_p1  <= '0;
            vld_p1   <= 1'b0;
            blank_p1 <= 1'b0;
            row_p1   <= '0;
            col_p1   <= '0;
            fs_p1    <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    dout_p1  <= slot_pixel;
                    vld_p1   <= 1'b1;
                    blank_p1 <= 1'b0;
                    row_p1   <= v;
                    col_p1   <= h;
                    fs_p1    <= (h == '0) && (v == '0);
                end
                HBLANK, VBLANK: begin
                    dout_p1  <= BLANK_FILL;
                    vld_p1   <= 1'b0;
                    blank_p1 <= 1'b1;
                    row_p1   <= v;
                    col_p1   <= h;
                    fs_p1    <= 1'b0;
                end
                default: begin
                    dout_p1  <= '0;
                    vld_p1   <= 1'b0;
                    blank_p1 <= 1'b0;
                    row_p1   <= '0;
                    col_p1   <= '0;
                    fs_p1    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            underflow_q <= 1'b0;
        end else if ((state == ACTIVE) && !pat_q && !din_valid) begin
            underflow_q <= 1'b1;
        end
    end

    assign dout           = dout_p1;
    assign validout       = vld_p1;
    assign blankingregion = blank_p1;
    assign rowcount       = row_p1;
    assign colcount       = col_p1;
    assign frame_start    = fs_p1;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_raster_stream_source.sv
module tb_raster_stream_source;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 3;
    localparam int VB = 1;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FR = HT * VT;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       run       = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
`ifdef RASTER_TEST_PATTERN_EN
    logic       pattern_sel = 1'b0;
`endif

    logic       din_ready;
    logic [7:0] dout;
    logic       validout;
    logic       blankingregion;
    logic [9:0] rowcount;
    logic [9:0] colcount;
    logic       frame_start;
    logic       underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    raster_stream_source #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .din            (din),
        .din_valid      (din_valid),
`ifdef RASTER_TEST_PATTERN_EN
        .pattern_sel    (pattern_sel),
`endif
        .din_ready      (din_ready),
        .dout           (dout),
        .validout       (validout),
        .blankingregion (blankingregion),
        .rowcount       (rowcount),
        .colcount       (colcount),
        .frame_start    (frame_start),
        .underflow      (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge. The upstream
    // model advances din only when it actually handed over a pixel.
    task automatic tick();
        logic popped;
        popped = din_ready && din_valid;
        @(posedge clock);
        #1;
        if (popped) din = din + 8'd1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nv;
        int   vcount;
        int   fscount;
        int   fs_pos[3];
        logic active;
        logic [7:0] px_r1c0;

        nv      = 0;
        vcount  = 0;
        fscount = 0;
        px_r1c0 = 8'h00;

        // ---------------- reset state ----------------
        reset = 1'b0;
        tick();
        tick();
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_validout", 32'(validout), 32'd0);
        check("rst_blank", 32'(blankingregion), 32'd0);
        check("rst_row", 32'(rowcount), 32'd0);
        check("rst_col", 32'(colcount), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // ---------------- frame 1: incrementing pixels, run dropped in row 1 ----------------
        reset     = 1'b1;
        run       = 1'b1;
        din_valid = 1'b1;
        din       = 8'h10;
        tick();
        check("start_din_ready", 32'(din_ready), 32'd1);
        check("start_no_valid", 32'(validout), 32'd0);

        for (int i = 0; i < FR; i++) begin
            if (i == HT) run = 1'b0;
            tick();
            active = ((i / HT) < VA) && ((i % HT) < HA);
            check("f1_row", 32'(rowcount), 32'(i / HT));
            check("f1_col", 32'(colcount), 32'(i % HT));
            check("f1_valid", 32'(validout), 32'(active));
            check("f1_blank", 32'(blankingregion), 32'(!active));
            check("f1_frame_start", 32'(frame_start), 32'(i == 0));
            if (active) begin
                check("f1_dout", 32'(dout), 32'h10 + 32'(nv));
                nv++;
            end
            if (i == HT) px_r1c0 = dout;
            if (validout) vcount++;
        end
        check("f1_valid_count", 32'(vcount), 32'd12);
        check("f1_r1c0_pixel", 32'(px_r1c0), 32'h14);

        for (int k = 0; k < 4; k++) begin
            check("idle_din_ready", 32'(din_ready), 32'd0);
            tick();
            check("idle_validout", 32'(validout), 32'd0);
            check("idle_blank", 32'(blankingregion), 32'd0);
        end

        // ---------------- underflow at slot (2,3) ----------------
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        run       = 1'b1;
        din_valid = 1'b1;
        din       = 8'h20;
        tick();
        for (int i = 0; i < FR; i++) begin
            if (i == 2) run = 1'b0;
            din_valid = (i != 2 * HT + 3);
            tick();
            if (i == 2 * HT + 2) check("uf_before", 32'(underflow), 32'd0);
            if (i == 2 * HT + 3) begin
                check("uf_row", 32'(rowcount), 32'd2);
                check("uf_col", 32'(colcount), 32'd3);
                check("uf_dout", 32'(dout), 32'h00);
                check("uf_validout", 32'(validout), 32'd1);
            end
            if (i >= 2 * HT + 3) check("uf_sticky", 32'(underflow), 32'd1);
        end
        din_valid = 1'b1;
        tick();
        tick();
        check("uf_sticky_idle", 32'(underflow), 32'd1);
        reset = 1'b0;
        tick();
        check("uf_cleared", 32'(underflow), 32'd0);

        // ---------------- reset mid-frame at (1,2) ----------------
        reset = 1'b1;
        run   = 1'b1;
        din   = 8'h30;
        tick();
        for (int i = 0; i < HT + 2; i++) tick();
        check("mid_row", 32'(rowcount), 32'd1);
        check("mid_col", 32'(colcount), 32'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_validout", 32'(validout), 32'd0);
        check("mid_rst_blank", 32'(blankingregion), 32'd0);
        check("mid_rst_row", 32'(rowcount), 32'd0);
        check("mid_rst_col", 32'(colcount), 32'd0);
        check("mid_rst_fs", 32'(frame_start), 32'd0);
        check("mid_rst_din_ready", 32'(din_ready), 32'd0);

        reset = 1'b1;
        run   = 1'b1;
        tick();
        check("restart_fs_early", 32'(frame_start), 32'd0);
        check("restart_valid_early", 32'(validout), 32'd0);

        // ---------------- three back-to-back frames ----------------
        vcount  = 0;
        fscount = 0;
        for (int j = 0; j < 3 * FR; j++) begin
            if (j == 2 * FR + 2) run = 1'b0;
            tick();
            if (j == 0) begin
                check("restart_fs", 32'(frame_start), 32'd1);
                check("restart_row", 32'(rowcount), 32'd0);
                check("restart_col", 32'(colcount), 32'd0);
            end
            if (frame_start) begin
                if (fscount < 3) fs_pos[fscount] = j;
                fscount++;
            end
            if (validout) vcount++;
        end
        check("f3_fs_count", 32'(fscount), 32'd3);
        if (fscount >= 3) begin
            check("f3_fs_gap1", 32'(fs_pos[1] - fs_pos[0]), 32'd24);
            check("f3_fs_gap2", 32'(fs_pos[2] - fs_pos[1]), 32'd24);
        end
        check("f3_valid_count", 32'(vcount), 32'd36);
        tick();
        check("f3_idle_valid", 32'(validout), 32'd0);
        check("f3_idle_din_ready", 32'(din_ready), 32'd0);

`ifdef RASTER_TEST_PATTERN_EN
        // ---------------- test pattern frame ----------------
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        pattern_sel = 1'b1;
        din_valid   = 1'b0;
        run         = 1'b1;
        tick();
        for (int i = 0; i < FR; i++) begin
            if (i == 1) begin
                run         = 1'b0;
                pattern_sel = 1'b0;
            end
            check("pat_din_ready", 32'(din_ready), 32'd0);
            tick();
            if (i == 2) check("pat_r0c2", 32'(dout), 32'h02);
            if (i == 2 * HT + 3) begin
                check("pat_r2c3", 32'(dout), 32'h01);
                check("pat_r2c3_valid", 32'(validout), 32'd1);
            end
        end
        check("pat_no_underflow", 32'(underflow), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
